mac_sequencer: RTL and testbench

//  Top-level sequencer for the Minilab1B matrix-vector datapath. On a start

---
 rtl/mac_seq_if.sv | 29 ++
 rtl/mac_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mac_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_if.sv
// Handshake and datapath-control bundle between the Minilab1B sequencer and
// its environment (fill unit, FIFOs, MAC array).
interface mac_seq_if #(
    parameter int NUM_FIFOS  = 9,
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  fill;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  fill_done;
    logic [NUM_FIFOS-1:0]  fifo_empty;
    logic [NUM_FIFOS-1:0]  fifo_rden;
    logic                  mac_clr;
    logic [NUM_FIFOS-2:0]  mac_en;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, base_addr, fill_done, fifo_empty,
        input  fill, fill_addr, fifo_rden, mac_clr, mac_en, busy, done, err
    );

    modport slave (
        input  start, base_addr, fill_done, fifo_empty,
        output fill, fill_addr, fifo_rden, mac_clr, mac_en, busy, done, err
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequencer for the Minilab1B matrix-vector datapath: fill FIFOs, clear the
// MACs, stream skewed read/MAC enables, then report done or a sticky error.
module mac_sequencer #(
    parameter int NUM_FIFOS    = 9,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAC_LAT      = 2,
    parameter int FILL_TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     rst,
    mac_seq_if.slave bus_if
);
    localparam int ROWS    = NUM_FIFOS - 1;
    localparam int RUN_LEN = DEPTH + ROWS - 1;
    localparam int CNT_W   = $clog2(RUN_LEN + MAC_LAT + 1);
    localparam int TMO_W   = $clog2(FILL_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WAIT  = 3'd2,
        S_CLR   = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic                  err_q, err_d;
    logic                  fill_q, fill_d;
    logic                  mac_clr_q, mac_clr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_FIFOS-1:0]  rden_q, rden_d;
    logic [ROWS-1:0]       mac_en_q, mac_en_d;
    logic [NUM_FIFOS-1:0]  rden_want_s;
    logic                  underflow_s;

    // Systolic skew: row i reads during RUN cycles i..i+DEPTH-1, the B vector during 0..DEPTH-1.
    function automatic logic [NUM_FIFOS-1:0] rden_pattern(input logic [CNT_W-1:0] c);
        logic [NUM_FIFOS-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            r[i] = (int'(c) >= i) && (int'(c) <= i + DEPTH - 1);
        end
        r[ROWS] = (int'(c) <= DEPTH - 1);
        return r;
    endfunction

    // Next-state and next-output decode; outputs are loaded for the cycle being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        fill_addr_d = fill_addr_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    state_d     = S_FILL;
                    fill_addr_d = bus_if.base_addr;
                    err_d       = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                // fill_done takes priority over a timeout landing in the same cycle
                if (bus_if.fill_done) begin
                    state_d = S_CLR;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CLR: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_RUN) begin
            rden_want_s = rden_pattern(cnt_d);
        end else begin
            rden_want_s = '0;
        end
        // Empty flags are judged at the edge that would launch the read.
        underflow_s = |(rden_want_s & bus_if.fifo_empty);

        if (underflow_s) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            rden_d   = '0;
            mac_en_d = '0;
        end else begin
            rden_d   = rden_want_s;
            mac_en_d = rden_q[ROWS-1:0];
        end

        fill_d    = (state_d == S_FILL);
        mac_clr_d = (state_d == S_CLR);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            fill_addr_q <= '0;
            err_q       <= 1'b0;
            fill_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rden_q      <= '0;
            mac_en_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            fill_addr_q <= fill_addr_d;
            err_q       <= err_d;
            fill_q      <= fill_d;
            mac_clr_q   <= mac_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rden_q      <= rden_d;
            mac_en_q    <= mac_en_d;
        end
    end

    assign bus_if.fill      = fill_q;
    assign bus_if.fill_addr = fill_addr_q;
    assign bus_if.fifo_rden = rden_q;
    assign bus_if.mac_clr   = mac_clr_q;
    assign bus_if.mac_en    = mac_en_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.done      = done_q;
    assign bus_if.err       = err_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: stimulus pushes per-operation summaries
// from a reference model, a monitor rebuilds the same summary from the pins.
module tb_mac_sequencer;
    localparam int NF      = 9;
    localparam int ROWS    = NF - 1;
    localparam int DEPTH   = 8;
    localparam int MAC_LAT = 2;
    localparam int FT      = 16;
    localparam int RUN_LEN = DEPTH + ROWS - 1;

    typedef struct {
        int                len;
        int                fill_n;
        int                clr_n;
        int                clr_cyc;
        int                done_n;
        logic              err;
        logic [31:0]       addr;
        logic [NF-1:0][7:0] rd_n;
        logic [NF-1:0][7:0] rd_first;
        logic [NF-1:0][7:0] me_n;
        logic [NF-1:0][7:0] me_first;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    mac_seq_if #(.NUM_FIFOS(NF), .ADDR_WIDTH(32)) bus ();

    mac_sequencer #(
        .NUM_FIFOS(NF), .DEPTH(DEPTH), .ADDR_WIDTH(32),
        .MAC_LAT(MAC_LAT), .FILL_TIMEOUT(FT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_if(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit active(input int i, input int c);
        if (i < ROWS) return (c >= i) && (c <= i + DEPTH - 1);
        return c <= DEPTH - 1;
    endfunction

    // Reference: w = WAIT_FILL cycles, tmo = fill never arrives, ab = RUN cnt at which underflow hits (-1 none).
    function automatic exp_t model(input logic [31:0] addr, input int w, input bit tmo, input int ab);
        exp_t e;
        int   runs;
        int   me_last;
        e.addr = addr; e.fill_n = 1; e.clr_n = 0; e.clr_cyc = 0; e.done_n = 0;
        e.rd_n = '0; e.rd_first = '0; e.me_n = '0; e.me_first = '0;
        if (tmo) begin
            e.len = 1 + FT;
            e.err = 1'b1;
            return e;
        end
        runs    = (ab < 0) ? RUN_LEN : ab;
        me_last = (ab < 0) ? runs - 1 : runs - 2;
        e.clr_n   = 1;
        e.clr_cyc = 1 + w;
        e.err     = (ab >= 0);
        e.done_n  = (ab < 0) ? 1 : 0;
        e.len     = (ab < 0) ? 1 + w + 1 + RUN_LEN + MAC_LAT + 1 : 2 + w + runs;
        for (int i = 0; i < NF; i++) begin
            for (int c = 0; c < runs; c++) begin
                if (active(i, c)) begin
                    if (e.rd_n[i] == 8'd0) e.rd_first[i] = 8'(2 + w + c);
                    e.rd_n[i] = e.rd_n[i] + 8'd1;
                    if (i < ROWS && c <= me_last) begin
                        if (e.me_n[i] == 8'd0) e.me_first[i] = 8'(3 + w + c);
                        e.me_n[i] = e.me_n[i] + 8'd1;
                    end
                end
            end
        end
        return e;
    endfunction

    // Monitor state
    bit   mon_active = 1'b0;
    int   cyc, fill_n, fill_cyc, clr_n, clr_cyc, done_n, done_cyc;
    int   rd_n [NF];
    int   rd_first [NF];
    int   me_n [NF];
    int   me_first [NF];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (bus.busy) begin
            if (!mon_active) begin
                mon_active = 1'b1;
                cyc = 0; fill_n = 0; fill_cyc = -1; clr_n = 0; clr_cyc = -1; done_n = 0; done_cyc = -1;
                for (int i = 0; i < NF; i++) begin
                    rd_n[i] = 0; rd_first[i] = 0; me_n[i] = 0; me_first[i] = 0;
                end
                check("err_cleared_on_start", bus.err, 0);
            end
            if (bus.fill) begin fill_n++; fill_cyc = cyc; end
            if (bus.mac_clr) begin clr_n++; clr_cyc = cyc; end
            if (bus.done) begin done_n++; done_cyc = cyc; end
            for (int i = 0; i < NF; i++) begin
                if (bus.fifo_rden[i]) begin
                    if (rd_n[i] == 0) rd_first[i] = cyc;
                    rd_n[i]++;
                end
                if (i < ROWS && bus.mac_en[i]) begin
                    if (me_n[i] == 0) me_first[i] = cyc;
                    me_n[i]++;
                end
            end
            cyc++;
        end else if (mon_active) begin
            mon_active = 1'b0;
            check("txn_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("busy_len", cyc, mon_e.len);
                check("fill_count", fill_n, mon_e.fill_n);
                check("fill_cycle", fill_cyc, 0);
                check("fill_addr", bus.fill_addr, mon_e.addr);
                check("clr_count", clr_n, mon_e.clr_n);
                if (mon_e.clr_n > 0) check("clr_cycle", clr_cyc, mon_e.clr_cyc);
                check("done_count", done_n, mon_e.done_n);
                if (mon_e.done_n > 0) check("done_cycle", done_cyc, mon_e.len - 1);
                check("err_after", bus.err, mon_e.err);
                for (int i = 0; i < NF; i++) begin
                    check($sformatf("rden%0d_count", i), rd_n[i], mon_e.rd_n[i]);
                    if (mon_e.rd_n[i] != 8'd0) check($sformatf("rden%0d_first", i), rd_first[i], mon_e.rd_first[i]);
                    if (i < ROWS) begin
                        check($sformatf("mac_en%0d_count", i), me_n[i], mon_e.me_n[i]);
                        if (mon_e.me_n[i] != 8'd0) check($sformatf("mac_en%0d_first", i), me_first[i], mon_e.me_first[i]);
                    end
                end
                check("idle_rden", bus.fifo_rden, 0);
                check("idle_mac_en", bus.mac_en, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from an IDLE cycle; returns in the first IDLE cycle after it.
    task automatic op(input logic [31:0] addr, input int w, input bit tmo,
                      input int ab, input int ab_fifo, input bit poke, input bit b2b);
        exp_t e;
        e = model(addr, w, tmo, ab);
        exp_q.push_back(e);
        bus.start = 1'b1; bus.base_addr = addr;
        tick();
        for (int r = 0; r < e.len; r++) begin
            bus.fill_done  = !tmo && (r == w);
            // empty seen at the edge that would launch RUN cnt = ab
            bus.fifo_empty = (ab >= 0 && r == w + 1 + ab) ? (NF'(1) << ab_fifo) : '0;
            if (poke && r == w + 6) begin
                bus.start = 1'b1; bus.base_addr = 32'h200;
            end else if (b2b && r == e.len - 1) begin
                bus.start = 1'b1; bus.base_addr = 32'hDEAD_0000;
            end else begin
                bus.start = 1'b0; bus.base_addr = $urandom;
            end
            tick();
        end
        bus.start = 1'b0; bus.fill_done = 1'b0; bus.fifo_empty = '0;
    endtask

    task automatic reset_mid_run(input int w);
        logic [NF-1:0] exp_r;
        bus.start = 1'b1; bus.base_addr = 32'h180;
        tick();
        bus.start = 1'b0;
        for (int r = 0; r < 2 + w + 6; r++) begin
            bus.fill_done = (r == w);
            tick();
        end
        bus.fill_done = 1'b0;
        for (int i = 0; i < NF; i++) exp_r[i] = active(i, 6);
        check("rden_at_cnt6", bus.fifo_rden, exp_r);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_rden", bus.fifo_rden, 0);
        check("rst_mac_en", bus.mac_en, 0);
        check("rst_fill_addr", bus.fill_addr, 0);
        check("rst_misc", {bus.fill, bus.mac_clr, bus.done, bus.err}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int w, ab, j;
        bit tmo;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.fill_done = 1'b0; bus.fifo_empty = '0;
        repeat (3) tick();
        check("reset_busy", bus.busy, 0);
        check("reset_fill_addr", bus.fill_addr, 0);
        check("reset_rden", bus.fifo_rden, 0);
        check("reset_mac_en", bus.mac_en, 0);
        check("reset_misc", {bus.fill, bus.mac_clr, bus.done, bus.err}, 0);
        rst = 1'b0;
        tick();

        op(32'h100, 12, 1'b0, -1, 0, 1'b0, 1'b0);   // nominal
        op(32'h104, 0, 1'b1, -1, 0, 1'b0, 1'b0);    // fill timeout
        tick();
        op(32'h108, 5, 1'b0, 5, 3, 1'b0, 1'b0);     // underflow on FIFO 3 at cnt 5
        tick();
        op(32'h100, 3, 1'b0, -1, 0, 1'b1, 1'b0);    // start while busy is ignored
        reset_mid_run(4);
        op(32'h140, 12, 1'b0, -1, 0, 1'b0, 1'b0);   // full sequence after reset
        op(32'h150, 2, 1'b0, -1, 0, 1'b0, 1'b1);    // start in DONE ignored
        op(32'h160, 4, 1'b0, -1, 0, 1'b0, 1'b0);    // accepted in following IDLE
        op(32'h170, FT, 1'b0, -1, 0, 1'b0, 1'b0);   // fill_done on the timeout cycle wins
        op(32'h174, 1, 1'b0, 0, 8, 1'b0, 1'b0);     // underflow on the very first read
        op(32'h178, 1, 1'b0, RUN_LEN - 1, 7, 1'b0, 1'b0); // underflow on the last read

        for (int k = 0; k < 24; k++) begin
            w   = $urandom_range(FT, 1);
            tmo = ($urandom_range(7, 0) == 0);
            ab  = -1;
            j   = 0;
            if (!tmo && $urandom_range(2, 0) == 0) begin
                j  = $urandom_range(NF - 1, 0);
                ab = (j < ROWS) ? $urandom_range(j + DEPTH - 1, j) : $urandom_range(DEPTH - 1, 0);
            end
            op($urandom, w, tmo, ab, j, 1'b0, 1'b0);
            repeat ($urandom_range(2, 0)) tick();
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
